// File: rtl/hex_keypad_entry_if.sv
// Keypad-side signal bundle for hex_keypad_entry: row/clear come in, column strobes,
// key events and the accumulated entry value go out.
interface hex_keypad_entry_if;
  logic [3:0]  row;
  logic        clear;
  logic [3:0]  col;
  logic        keyValid;
  logic [3:0]  keyCode;
  logic [15:0] entryVal;

  modport master (
    output row, clear,
    input  col, keyValid, keyCode, entryVal
  );

  modport slave (
    input  row, clear,
    output col, keyValid, keyCode, entryVal
  );
endinterface

// File: rtl/hex_keypad_entry.sv
// 4x4 matrix keypad scanner with debounce; accepted hex digits shift into a
// 16-bit entry register that drives the display value directly.
module hex_keypad_entry #(
  parameter int SCAN_DIV       = 1023,
  parameter int DEBOUNCE_TICKS = 4
) (
  input logic             clk5,
  input logic             reset,
  hex_keypad_entry_if.slave kp
);

  localparam logic [9:0] DivLast = 10'(SCAN_DIV);
  localparam logic [3:0] DebLast = 4'(DEBOUNCE_TICKS);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} keyState_e;

  keyState_e   state, stateNext;
  logic [9:0]  divCnt;
  logic        tick;
  logic [3:0]  rowMeta, rowS;
  logic [3:0]  rowLat, rowLatNext;
  logic [3:0]  debCnt, debCntNext;
  logic [3:0]  relCnt, relCntNext;
  logic [1:0]  colIdx, colIdxNext;
  logic [1:0]  rowIdx;
  logic        oneLow;
  logic        accept;
  logic        keyValidR;
  logic [3:0]  keyCodeR;
  logic [15:0] entryValR;

  assign tick = (divCnt == DivLast);

  // Two simultaneous rows low means a ghosted or multi-key press, so only a
  // single low row is treated as a candidate key.
  always_comb begin
    oneLow = 1'b0;
    case (rowS)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: oneLow = 1'b1;
      default:                            oneLow = 1'b0;
    endcase
  end

  always_comb begin
    rowIdx = 2'd0;
    case (rowLat)
      4'b1101: rowIdx = 2'd1;
      4'b1011: rowIdx = 2'd2;
      4'b0111: rowIdx = 2'd3;
      default: rowIdx = 2'd0;
    endcase
  end

  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      divCnt  <= 10'd0;
      rowMeta <= 4'hF;
      rowS    <= 4'hF;
      state   <= SCAN;
      colIdx  <= 2'd0;
      rowLat  <= 4'hF;
      debCnt  <= 4'd0;
      relCnt  <= 4'd0;
    end else begin
      divCnt  <= tick ? 10'd0 : divCnt + 10'd1;
      rowMeta <= kp.row;
      rowS    <= rowMeta;
      state   <= stateNext;
      colIdx  <= colIdxNext;
      rowLat  <= rowLatNext;
      debCnt  <= debCntNext;
      relCnt  <= relCntNext;
    end
  end

  // The column is frozen from first detection until release is confirmed, so
  // the latched row and current column together identify the key.
  always_comb begin
    stateNext  = state;
    colIdxNext = colIdx;
    rowLatNext = rowLat;
    debCntNext = debCnt;
    relCntNext = relCnt;
    accept     = 1'b0;
    if (tick) begin
      case (state)
        SCAN: begin
          if (oneLow) begin
            rowLatNext = rowS;
            debCntNext = 4'd1;
            stateNext  = DEBOUNCE;
          end else begin
            colIdxNext = colIdx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (rowS == rowLat) begin
            debCntNext = debCnt + 4'd1;
            if (debCnt + 4'd1 == DebLast) begin
              accept     = 1'b1;
              relCntNext = 4'd0;
              stateNext  = HELD;
            end
          end else begin
            stateNext  = SCAN;
            colIdxNext = colIdx + 2'd1;
          end
        end
        HELD: begin
          if (rowS == 4'hF) begin
            relCntNext = relCnt + 4'd1;
            if (relCnt + 4'd1 == DebLast) begin
              stateNext  = SCAN;
              colIdxNext = colIdx + 2'd1;
            end
          end else begin
            relCntNext = 4'd0;
          end
        end
        default: stateNext = SCAN;
      endcase
    end
  end

  // A coincident clear beats the shift, but the key event itself still fires.
  always_ff @(posedge clk5 or posedge reset) begin
    if (reset) begin
      keyValidR <= 1'b0;
      keyCodeR  <= 4'd0;
      entryValR <= 16'd0;
    end else begin
      keyValidR <= accept;
      if (accept)
        keyCodeR <= {rowIdx, colIdx};
      if (kp.clear)
        entryValR <= 16'd0;
      else if (accept)
        entryValR <= {entryValR[11:0], rowIdx, colIdx};
    end
  end

  assign kp.col      = ~(4'b0001 << colIdx);
  assign kp.keyValid = keyValidR;
  assign kp.keyCode  = keyCodeR;
  assign kp.entryVal = entryValR;

endmodule

// File: tb/tb_hex_keypad_entry.sv
// Scoreboard bench for hex_keypad_entry: a keypad model drives rows from the
// strobed column, and a monitor checks every key event against queued expectations.
module tb_hex_keypad_entry;

  typedef struct {
    logic [3:0]  code;
    logic [15:0] entry;
  } expT;

  logic clk5;
  logic reset;
  hex_keypad_entry_if kif ();

  logic       keyDown;
  logic [3:0] rowPattern;
  logic [1:0] keyC;
  logic       forceEn;
  logic [3:0] forceRow;
  expT        expQ[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         seenEvents = 0;

  hex_keypad_entry #(.SCAN_DIV(3), .DEBOUNCE_TICKS(2)) dut (
    .clk5  (clk5),
    .reset (reset),
    .kp    (kif)
  );

  initial clk5 = 1'b0;
  always #5 clk5 = ~clk5;

  // Matrix model: the pressed key pulls its row low only while its column is strobed.
  assign kif.row = forceEn ? forceRow :
                   ((keyDown && (kif.col[keyC] == 1'b0)) ? rowPattern : 4'hF);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic waitEvent(input string name);
    int start;
    int n;
    start = seenEvents;
    n = 0;
    while (seenEvents == start && n < 200) begin
      @(negedge clk5);
      n++;
    end
    if (seenEvents == start) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s: no keyValid within 200 cycles", name);
    end
  endtask

  task automatic countColChanges(input int cycles, output int changes);
    logic [3:0] prev;
    changes = 0;
    prev = kif.col;
    repeat (cycles) begin
      @(negedge clk5);
      if (kif.col !== prev) changes++;
      prev = kif.col;
    end
  endtask

  task automatic pressKey(input logic [3:0] code, input logic [15:0] expEntry);
    expQ.push_back('{code: code, entry: expEntry});
    rowPattern = ~(4'b0001 << code[3:2]);
    keyC       = code[1:0];
    keyDown    = 1'b1;
    waitEvent($sformatf("event key %0h", code));
  endtask

  task automatic applyStimulus(input logic [3:0] code, input logic [15:0] expEntry);
    pressKey(code, expEntry);
    repeat (8) @(negedge clk5);
    keyDown = 1'b0;
    repeat (24) @(negedge clk5);
  endtask

  task automatic asyncReset();
    @(posedge clk5);
    #3 reset = 1'b1;
    #1;
    checkOutput("reset col", kif.col, 4'b1110);
    checkOutput("reset keyValid", kif.keyValid, 1'b0);
    checkOutput("reset keyCode", kif.keyCode, 4'h0);
    checkOutput("reset entryVal", kif.entryVal, 16'h0000);
  endtask

  // Monitor: every keyValid pulse pops one expectation and checks code and entry.
  initial begin : monitor
    logic prevKv;
    expT  e;
    prevKv = 1'b0;
    forever begin
      @(negedge clk5);
      if (reset !== 1'b0) begin
        prevKv = 1'b0;
      end else begin
        if (kif.keyValid === 1'b1) begin
          checkOutput("keyValid single-cycle", prevKv, 1'b0);
          if (expQ.size() == 0) begin
            checkOutput("unexpected keyValid code", kif.keyCode, 4'hx);
          end else begin
            e = expQ.pop_front();
            checkOutput("keyCode", kif.keyCode, e.code);
            checkOutput("entryVal at event", kif.entryVal, e.entry);
          end
          seenEvents++;
        end
        prevKv = (kif.keyValid === 1'b1);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    logic [3:0] prev;
    int lastChange;
    int changes;
    int bad;
    reset      = 1'b0;
    keyDown    = 1'b0;
    rowPattern = 4'hF;
    keyC       = 2'd0;
    forceEn    = 1'b0;
    forceRow   = 4'hF;
    kif.clear  = 1'b0;

    asyncReset();
    repeat (2) @(negedge clk5);
    reset = 1'b0;

    // Idle scan: col rotates every 4 cycles in the fixed order.
    prev = kif.col;
    checkOutput("idle start col", prev, 4'b1110);
    changes = 0;
    lastChange = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk5);
      if (kif.col !== prev) begin
        checkOutput("idle col rotate", kif.col, {prev[2:0], prev[3]});
        if (lastChange >= 0) checkOutput("idle col period", i - lastChange, 4);
        lastChange = i;
        changes++;
      end
      prev = kif.col;
    end
    checkOutput("idle col changes", changes >= 4, 1'b1);

    // Single press of key 6 (row 1, column 2); column stays frozen while held.
    pressKey(4'h6, 16'h0006);
    bad = 0;
    repeat (30) begin
      @(negedge clk5);
      if (kif.col !== 4'b1011) bad++;
    end
    checkOutput("held col frozen", bad, 0);
    keyDown = 1'b0;
    bad = 0;
    repeat (5) begin
      @(negedge clk5);
      if (kif.col !== 4'b1011) bad++;
    end
    checkOutput("col held until release debounced", bad, 0);
    countColChanges(20, changes);
    checkOutput("scan resumes after release", changes >= 1, 1'b1);
    repeat (8) @(negedge clk5);

    applyStimulus(4'hA, 16'h006A);
    applyStimulus(4'hB, 16'h06AB);
    applyStimulus(4'hC, 16'h6ABC);
    applyStimulus(4'hD, 16'hABCD);
    applyStimulus(4'h5, 16'hBCD5);

    // Bounce: one tick of a low row must not produce an event.
    forceRow = 4'b1110;
    forceEn  = 1'b1;
    repeat (4) @(negedge clk5);
    forceEn  = 1'b0;
    countColChanges(24, changes);
    checkOutput("bounce entryVal unchanged", kif.entryVal, 16'hBCD5);
    checkOutput("bounce scan continues", changes >= 3, 1'b1);

    // Ghost: two rows low is ignored and scanning keeps going.
    forceRow = 4'b1100;
    forceEn  = 1'b1;
    countColChanges(40, changes);
    checkOutput("ghost col rotating", changes >= 8, 1'b1);
    forceEn  = 1'b0;
    repeat (8) @(negedge clk5);
    checkOutput("ghost entryVal unchanged", kif.entryVal, 16'hBCD5);

    applyStimulus(4'h1, 16'hCD51);
    applyStimulus(4'h2, 16'hD512);
    applyStimulus(4'h3, 16'h5123);
    applyStimulus(4'h4, 16'h1234);

    // Clear pulse on its own.
    checkOutput("entryVal before clear", kif.entryVal, 16'h1234);
    kif.clear = 1'b1;
    @(negedge clk5);
    kif.clear = 1'b0;
    checkOutput("entryVal after clear", kif.entryVal, 16'h0000);

    // Clear held across the accept of key 7: clear wins over the shift.
    kif.clear = 1'b1;
    pressKey(4'h7, 16'h0000);
    kif.clear = 1'b0;
    repeat (8) @(negedge clk5);
    keyDown = 1'b0;
    repeat (24) @(negedge clk5);

    // Reset while key 9 is held, then re-detection after reset release.
    pressKey(4'h9, 16'h0009);
    repeat (6) @(negedge clk5);
    asyncReset();
    repeat (3) @(negedge clk5);
    expQ.push_back('{code: 4'h9, entry: 16'h0009});
    reset = 1'b0;
    waitEvent("re-detect after reset");
    repeat (8) @(negedge clk5);
    keyDown = 1'b0;
    repeat (30) @(negedge clk5);

    checkOutput("scoreboard drained", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
